alu_secuenciador: RTL

Control/operand stage that sits directly around the combinational ALU. It collects A, B and the opcode as three beats on one valid/ready input bus and drives them, registered, onto the ALU's A/B/sel_alu inputs. It then captures the ALU result into an output register with a zero flag and offers it downstream on a valid/ready handshake. One operation is in flight at a time; there is no pipelining across operations.

---
 rtl/alu_secuenciador.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_secuenciador.sv
// Operand/control stage around a combinational ALU: loads A, B and opcode as
// three beats on one valid/ready bus, then registers the ALU result for handoff.
module alu_secuenciador #(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [ANCHO-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [ANCHO-1:0] alu_A,
  output logic [ANCHO-1:0] alu_B,
  output logic [2:0]       alu_sel,
  input  logic [ANCHO-1:0] alu_res,
  output logic [ANCHO-1:0] res,
  output logic             res_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [7:0]       op_count
);

  localparam logic [2:0] LOAD_A  = 3'd0;
  localparam logic [2:0] LOAD_B  = 3'd1;
  localparam logic [2:0] LOAD_OP = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;

  logic [2:0] state_r;
  logic       din_ready_s;
  logic       busy_s;
  logic       accept_s;

  function automatic logic is_zero(input logic [ANCHO-1:0] v);
    return (v == {ANCHO{1'b0}});
  endfunction

  // Handshake and status decode depend on state only, never on din_valid.
  always_comb begin
    din_ready_s = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      LOAD_A, LOAD_B, LOAD_OP: begin
        din_ready_s = 1'b1;
        busy_s      = 1'b0;
      end
      EXEC, HOLD: begin
        din_ready_s = 1'b0;
        busy_s      = 1'b1;
      end
      default: begin
        din_ready_s = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  assign din_ready = din_ready_s;
  assign busy      = busy_s;
  assign accept_s  = din_valid & din_ready_s;

  // Sequencer state, operand registers and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= LOAD_A;
      alu_A     <= {ANCHO{1'b0}};
      alu_B     <= {ANCHO{1'b0}};
      alu_sel   <= 3'b000;
      res       <= {ANCHO{1'b0}};
      res_zero  <= 1'b0;
      res_valid <= 1'b0;
      op_count  <= 8'd0;
    end else if (clr) begin
      // Abort keeps operands, last result and count; only the handshake drops.
      state_r   <= LOAD_A;
      res_valid <= 1'b0;
    end else begin
      case (state_r)
        LOAD_A: begin
          if (accept_s) begin
            alu_A   <= din;
            state_r <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (accept_s) begin
            alu_B   <= din;
            state_r <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (accept_s) begin
            alu_sel <= din[2:0];
            state_r <= EXEC;
          end
        end
        EXEC: begin
          res       <= alu_res;
          res_zero  <= is_zero(alu_res);
          res_valid <= 1'b1;
          state_r   <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state_r   <= LOAD_A;
          end
        end
        default: begin
          state_r   <= LOAD_A;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
